// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/loader arbiter for the shared single-port data memory
//
// Purpose: grants the single-port data memory to either the CPU load/store
// path or the external loader port. Each access holds mem_en for ACC_CYCLES
// cycles, then the winner gets a one-cycle ack, together with its read data
// if the access was a read.
//
// Parameters: AW address width, DW data width, ACC_CYCLES mem_en cycles per
// access (1..15).
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request; held until cpu_ack
//   cpu_ack, cpu_rdata         CPU completion pulse, last CPU read data
//   cpu_stall                  cpu_req & ~cpu_ack
//   ldr_req/we/addr/wdata      loader request; held until ldr_ack
//   ldr_ack, ldr_rdata         loader completion pulse, last loader read data
//   mem_en/we/addr/wdata       memory strobe, write enable, address, write data
//   mem_rdata                  memory read data, valid while mem_en is high
//   busy                       high whenever an access is in progress
//
// Configuration macro: MEM_ARB_FIXED_PRIO_EN. When it is defined the CPU
// always wins ties. When it is not defined, ties alternate round-robin.
module dmem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int ACC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  generate
    if (ACC_CYCLES < 1 || ACC_CYCLES > 15) begin : g_bad_acc_cycles
      $error("dmem_arbiter: ACC_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic       PORT_CPU = 1'b0;
  localparam logic       PORT_LDR = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_grant;
  logic       cur_ldr;
  logic       any_req;
  logic       pick_ldr;

  assign any_req = cpu_req | ldr_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // The loader wins only when the CPU is not asking.
  assign pick_ldr = ldr_req & ~cpu_req;
`else
  // On a tie, the port that was not served last time wins.
  assign pick_ldr = ldr_req & (~cpu_req | (last_grant == PORT_CPU));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered memory interface, acks and read data. The winner's request
  // fields are latched at grant time. This keeps the memory stable even if the
  // requester drops req in the middle of the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
      cnt        <= 4'd0;
      cur_ldr    <= PORT_CPU;
      last_grant <= PORT_LDR;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_ldr    <= pick_ldr;
            last_grant <= pick_ldr;
            mem_en     <= 1'b1;
            mem_we     <= pick_ldr ? ldr_we    : cpu_we;
            mem_addr   <= pick_ldr ? ldr_addr  : cpu_addr;
            mem_wdata  <= pick_ldr ? ldr_wdata : cpu_wdata;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we) begin
              if (cur_ldr) ldr_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            if (cur_ldr) ldr_ack <= 1'b1;
            else         cpu_ack <= 1'b1;
          end
        end
        RESP: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
        end
        default: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    cpu_stall = cpu_req & ~cpu_ack;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - testbench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int ACC = 3;

  logic       clk;
  logic       reset;
  logic       cpu_req, cpu_we, ldr_req, ldr_we;
  logic [7:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic       cpu_ack, cpu_stall, ldr_ack;
  logic [7:0] cpu_rdata, ldr_rdata;
  logic       mem_en, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] memory [256];
  logic [7:0] refmem [256];

  int errors = 0;
  int checks = 0;
  bit grants[$];

  // Reference model state.
  bit         m_active = 0;
  int         m_k = 0;
  bit         m_lg = 1;
  bit         m_ldr = 0;
  bit         m_we = 0;
  logic [7:0] m_addr = 0, m_wd = 0, m_rd = 0;
  logic [7:0] e_crd = 0, e_lrd = 0;

  dmem_arbiter #(.AW(8), .DW(8), .ACC_CYCLES(ACC)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign mem_rdata = mem_en ? memory[mem_addr] : ~memory[mem_addr];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    memory[a] = v;
    refmem[a] = v;
  endtask

  // Memory array behind the arbiter.
  initial forever begin
    @(posedge clk);
    if (mem_en && mem_we) memory[mem_addr] = mem_wdata;
  end

  // Transaction-level model. It counts edges since the grant:
  // k = 0..ACC-1 strobe the memory, k = ACC is the ack cycle, and the
  // model becomes idle again at k = ACC+1.
  task automatic model_step();
    if (!reset) begin
      m_active = 0; m_k = 0; m_lg = 1; e_crd = 0; e_lrd = 0;
    end else if (!m_active) begin
      if (cpu_req || ldr_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        m_ldr = !cpu_req;
`else
        m_ldr = (cpu_req && ldr_req) ? !m_lg : ldr_req;
`endif
        m_lg = m_ldr;
        m_active = 1;
        m_k = 0;
        m_we   = m_ldr ? ldr_we    : cpu_we;
        m_addr = m_ldr ? ldr_addr  : cpu_addr;
        m_wd   = m_ldr ? ldr_wdata : cpu_wdata;
        if (m_we) refmem[m_addr] = m_wd;
        else      m_rd = refmem[m_addr];
      end
    end else begin
      m_k++;
      if (m_k == ACC && !m_we) begin
        if (m_ldr) e_lrd = m_rd;
        else       e_crd = m_rd;
      end
      if (m_k == ACC + 1) m_active = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  // Compare every cycle against the model.
  initial forever begin
    bit e_en, e_ca, e_la;
    @(negedge clk);
    e_en = m_active && (m_k < ACC);
    e_ca = m_active && (m_k == ACC) && !m_ldr;
    e_la = m_active && (m_k == ACC) && m_ldr;
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_en && m_we);
    check("busy", busy, m_active);
    check("cpu_ack", cpu_ack, e_ca);
    check("ldr_ack", ldr_ack, e_la);
    check("cpu_rdata", cpu_rdata, e_crd);
    check("ldr_rdata", ldr_rdata, e_lrd);
    check("cpu_stall", cpu_stall, cpu_req && !e_ca);
    check("single_ack", cpu_ack && ldr_ack, 0);
    if (e_en) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, m_wd);
    end
    if (cpu_ack) grants.push_back(1'b0);
    if (ldr_ack) grants.push_back(1'b1);
  end

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (busy && c < 100);
    check(name, busy, 0);
  endtask

  task automatic wait_grants(input int n, input string name);
    for (int i = 0; i < 200 && grants.size() < n; i++) @(posedge clk);
    check(name, grants.size() >= n, 1);
  endtask

  task automatic drive_port(input bit ldr, input int n);
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (ldr) begin
        ldr_we = $urandom_range(0, 1); ldr_addr = 8'($urandom_range(0, 15));
        ldr_wdata = 8'($urandom); ldr_req = 1;
      end else begin
        cpu_we = $urandom_range(0, 1); cpu_addr = 8'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom); cpu_req = 1;
      end
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
        if (ldr) ldr_req = 0; else cpu_req = 0;
        continue;
      end
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        got = ldr ? ldr_ack : cpu_ack;
      end
      check(ldr ? "ldr_ack_timeout" : "cpu_ack_timeout", got, 1);
      @(posedge clk); #1;
      if (ldr) ldr_req = 0; else cpu_req = 0;
    end
  endtask

  initial begin
    bit [4:0] exp_order;
    int n_en, lat;
    for (int i = 0; i < 256; i++) begin
      memory[i] = 8'($urandom);
      refmem[i] = memory[i];
    end
    poke(8'h01, 8'h61);
    poke(8'h02, 8'h5B);
    poke(8'h10, 8'hA5);
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = 5'b10000;
`else
    exp_order = 5'b11010;
`endif
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01; cpu_wdata = 8'h00;
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h02; ldr_wdata = 8'h00;
    #2 reset = 0;

    // Reset held with both requests asserted.
    repeat (3) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ldr_rdata", ldr_rdata, 0);
    @(posedge clk); #1 reset = 1;
    grants.delete();
    @(posedge clk); #1;
    check("first_grant_en", mem_en, 1);
    check("first_grant_addr", mem_addr, 8'h01);

    // Both requests held: four grants, then the CPU drops out.
    wait_grants(4, "tie_grants_timeout");
    #1 cpu_req = 0;
    wait_grants(5, "ldr_after_cpu_drop_timeout");
    #1 ldr_req = 0;
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) check($sformatf("grant_order_%0d", i), grants[i], exp_order[i]);
    check("tie_cpu_rdata", cpu_rdata, 8'h61);
    check("tie_ldr_rdata", ldr_rdata, 8'h5B);
    wait_idle("idle_after_ties");

    // CPU read of 0x10.
    cpu_we = 0; cpu_addr = 8'h10; cpu_req = 1;
    n_en = 0; lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        n_en++;
        check("rd_addr", mem_addr, 8'h10);
        check("rd_we", mem_we, 0);
      end
      if (cpu_ack) lat = n;
    end
    check("rd_latency", lat, ACC + 1);
    check("rd_en_cycles", n_en, ACC);
    check("rd_cpu_rdata", cpu_rdata, 8'hA5);
    @(posedge clk); #1 cpu_req = 0;
    wait_idle("idle_after_read");

    // Loader write 0x20 <- 0x3C.
    ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 8'h3C; ldr_req = 1;
    n_en = 0; lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        n_en++;
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 8'h20);
        check("wr_wdata", mem_wdata, 8'h3C);
      end
      if (ldr_ack) lat = n;
    end
    check("wr_latency", lat, ACC + 1);
    check("wr_en_cycles", n_en, ACC);
    check("wr_ldr_rdata_kept", ldr_rdata, 8'h5B);
    check("wr_cpu_rdata_kept", cpu_rdata, 8'hA5);
    check("wr_memory", memory[8'h20], 8'h3C);
    @(posedge clk); #1 ldr_req = 0;
    wait_idle("idle_after_write");

    // Reset during the second access cycle.
    cpu_we = 0; cpu_addr = 8'h30; cpu_req = 1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 0;
    #1;
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cpu_ack", cpu_ack, 0);
    check("mid_rst_cpu_rdata", cpu_rdata, 0);
    cpu_req = 0;
    @(posedge clk); #1 reset = 1;
    repeat (ACC + 3) @(posedge clk);
    #1 check("post_rst_cpu_rdata", cpu_rdata, 0);

    // Randomized traffic from both ports.
    fork
      drive_port(1'b0, 60);
      drive_port(1'b1, 60);
    join
    wait_idle("idle_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
